// File: rtl/instr_encoder.sv
// RV32 instruction encoder: packs decoded fields plus a signed immediate into a 32-bit word,
// range-checks the immediate and tags each word with a sequential address. Optional macro: INSTR_ENC_SELFCHECK_EN.
module instr_encoder #(
  parameter int unsigned       DWIDTH    = 32,
  parameter int unsigned       AWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [DWIDTH-1:0] in_imm,
  input  logic              addr_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [AWIDTH-1:0] out_addr,
  output logic              out_imm_err,
  output logic [7:0]        err_count,
  output logic              selfcheck_fail
);

  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam int unsigned IHI_W      = DWIDTH - 11;
  localparam int unsigned BHI_W      = DWIDTH - 12;

  if (DWIDTH <= 12) begin : g_dwidth_chk
    $error("instr_encoder: DWIDTH must be greater than 12");
  end

  logic              r_out_valid;
  logic [31:0]       r_out_instr;
  logic [AWIDTH-1:0] r_out_addr;
  logic              r_out_imm_err;
  logic [7:0]        r_err_count;
  logic [AWIDTH-1:0] r_addr;

  logic              w_accept;
  logic              w_xfer;
  logic [AWIDTH-1:0] w_word_addr;
  logic [IHI_W-1:0]  w_i_hi;
  logic [BHI_W-1:0]  w_b_hi;
  logic              w_i_err;
  logic              w_b_err;
  logic [31:0]       w_instr;
  logic              w_imm_err;

  assign in_ready    = !r_out_valid || out_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_xfer      = r_out_valid && out_ready;
  assign w_word_addr = addr_clr ? BASE_ADDR : r_addr;

  // Immediate fits when every bit above the field's sign bit replicates it.
  assign w_i_hi  = in_imm[DWIDTH-1:11];
  assign w_b_hi  = in_imm[DWIDTH-1:12];
  assign w_i_err = !((&w_i_hi) || !(|w_i_hi));
  assign w_b_err = !((&w_b_hi) || !(|w_b_hi)) || in_imm[0];

  // Field packing by instruction format; unknown opcodes fall back to I-type.
  always_comb begin
    w_instr   = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
    w_imm_err = w_i_err;
    case (in_opcode)
      OPC_OP: begin
        w_instr   = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        w_imm_err = 1'b0;
      end
      OPC_STORE: begin
        w_instr   = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        w_imm_err = w_i_err;
      end
      OPC_BRANCH: begin
        w_instr   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
        w_imm_err = w_b_err;
      end
      default: begin
        w_instr   = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        w_imm_err = w_i_err;
      end
    endcase
  end

  // Output stage and address counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_instr   <= '0;
      r_out_addr    <= BASE_ADDR;
      r_out_imm_err <= 1'b0;
      r_err_count   <= '0;
      r_addr        <= BASE_ADDR;
    end else begin
      if (w_xfer && r_out_imm_err && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
      if (w_accept) begin
        r_out_valid   <= 1'b1;
        r_out_instr   <= w_instr;
        r_out_addr    <= w_word_addr;
        r_out_imm_err <= w_imm_err;
        r_addr        <= w_word_addr + AWIDTH'(4);
      end else begin
        if (addr_clr) begin
          r_addr <= BASE_ADDR;
        end
        if (w_xfer) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_instr   = r_out_instr;
  assign out_addr    = r_out_addr;
  assign out_imm_err = r_out_imm_err;
  assign err_count   = r_err_count;

`ifdef INSTR_ENC_SELFCHECK_EN
  logic [DWIDTH-1:0] r_imm;
  logic [DWIDTH-1:0] w_dec_imm;
  logic              w_sc_fail;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_imm <= '0;
    end else if (w_accept) begin
      r_imm <= in_imm;
    end
  end

  // Re-extract the immediate the way the core's decoder would.
  always_comb begin
    w_dec_imm = DWIDTH'($signed(r_out_instr[31:20]));
    case (r_out_instr[6:0])
      OPC_STORE:  w_dec_imm = DWIDTH'($signed({r_out_instr[31:25], r_out_instr[11:7]}));
      OPC_BRANCH: w_dec_imm = DWIDTH'($signed({r_out_instr[31], r_out_instr[7],
                                               r_out_instr[30:25], r_out_instr[11:8], 1'b0}));
      default:    w_dec_imm = DWIDTH'($signed(r_out_instr[31:20]));
    endcase
  end

  assign w_sc_fail = r_out_valid && !r_out_imm_err &&
                     (r_out_instr[6:0] != OPC_OP) && (w_dec_imm != r_imm);
  assign selfcheck_fail = w_sc_fail;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!w_sc_fail)
        else $error("instr_encoder: re-decoded immediate differs from captured immediate");
    end
  end
`else
  assign selfcheck_fail = 1'b0;
`endif

endmodule
